// File: rtl/gray_pkg.sv
// Shared constants, counter step encoding and Gray/binary conversion helpers.
package gray_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned GRAY_FN_W     = 32;

  typedef logic [GRAY_FN_W-1:0] gword_t;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_INC,
    ACT_DEC,
    ACT_WRAP_LO,
    ACT_WRAP_HI
  } action_e;

  function automatic gword_t bin2gray(input gword_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down recovers the binary value.
  function automatic gword_t gray2bin(input gword_t gray);
    gword_t b;
    b[GRAY_FN_W-1] = gray[GRAY_FN_W-1];
    for (int unsigned i = 1; i < GRAY_FN_W; i++) begin
      b[GRAY_FN_W-1-i] = b[GRAY_FN_W-i] ^ gray[GRAY_FN_W-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and count bus between a driver and the Gray counter.
interface gray_counter_if
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] bin;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, load, load_val,
    input  g, bin, tc, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output g, bin, tc, wrap
  );
endinterface

// File: rtl/gray_counter_enc.sv
// Pure combinational binary-reflected Gray encoder.
module binary_to_gray_enc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_counter.sv
// Up/down counter with binary state and a Gray output registered from the
// next binary value; parallel load, terminal-count and wrap-pulse flags.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter bit          WRAP  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  gray_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  action_e          act;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    act = ACT_HOLD;
    if (bus.load) begin
      act = ACT_LOAD;
    end else if (bus.en) begin
      if (bus.up) begin
        if (bin_q != ALL_ONES) act = ACT_INC;
        else if (WRAP)         act = ACT_WRAP_LO;
      end else begin
        if (bin_q != '0)       act = ACT_DEC;
        else if (WRAP)         act = ACT_WRAP_HI;
      end
    end
  end

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    case (act)
      ACT_LOAD:    bin_d = bus.load_val;
      ACT_INC:     bin_d = bin_q + WIDTH'(1);
      ACT_DEC:     bin_d = bin_q - WIDTH'(1);
      ACT_WRAP_LO: begin bin_d = '0; wrap_d = 1'b1; end
      ACT_WRAP_HI: begin bin_d = '1; wrap_d = 1'b1; end
      default:     bin_d = bin_q;
    endcase
  end

  // Gray is encoded from the next binary value so g_q and bin_q update together.
  binary_to_gray_enc #(.WIDTH(WIDTH)) u_enc (
    .bin  (bin_d),
    .gray (g_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.g    = g_q;
  assign bus.bin  = bin_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = (bus.up && (bin_q == ALL_ONES)) || (!bus.up && (bin_q == '0));

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: one wrapping and one saturating instance.
module tb_gray_counter;
  import gray_pkg::*;

  localparam int unsigned W = 4;

  localparam logic [3:0] GTAB [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  typedef struct {
    bit         sel;      // 0 = wrapping DUT, 1 = saturating DUT
    logic [3:0] bin;
    logic [3:0] g;
    logic       wrap;
    bit         chk_ham;
    logic [3:0] ham;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gray_counter_if #(.WIDTH(W)) ifw ();
  gray_counter_if #(.WIDTH(W)) ifs ();

  gray_counter #(.WIDTH(W), .WRAP(1'b1)) dut_w (.clk(clk), .rst(rst), .bus(ifw));
  gray_counter #(.WIDTH(W), .WRAP(1'b0)) dut_s (.clk(clk), .rst(rst), .bus(ifs));

  always #5 clk = ~clk;

  exp_t       sb [$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] mw, ms;
  logic [3:0] prev_gw, prev_gs;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] cur, input bit wrapmode,
                                input logic e, input logic u, input logic l,
                                input logic [3:0] lv,
                                output logic [3:0] nb, output logic wf);
    int v;
    wf = 1'b0;
    if (l) nb = lv;
    else if (!e) nb = cur;
    else begin
      v = int'(cur) + (u ? 1 : -1);
      if (v < 0 || v > 15) begin
        if (wrapmode) begin
          nb = 4'(v & 15);
          wf = 1'b1;
        end else begin
          nb = cur;
        end
      end else begin
        nb = 4'(v);
      end
    end
  endfunction

  function automatic logic [3:0] tc_of(input logic u, input logic [3:0] b);
    return {3'b000, (u && b == 4'hF) || (!u && b == 4'h0)};
  endfunction

  task automatic compare_one();
    exp_t       x;
    logic [3:0] og, ob, prev;
    logic       ow, otc, u;
    x = sb.pop_front();
    if (x.sel) begin
      og = ifs.g; ob = ifs.bin; ow = ifs.wrap; otc = ifs.tc; u = ifs.up; prev = prev_gs;
    end else begin
      og = ifw.g; ob = ifw.bin; ow = ifw.wrap; otc = ifw.tc; u = ifw.up; prev = prev_gw;
    end
    chk(x.sel ? "s_g" : "w_g", og, x.g);
    chk(x.sel ? "s_bin" : "w_bin", ob, x.bin);
    chk(x.sel ? "s_wrap" : "w_wrap", {3'b000, ow}, {3'b000, x.wrap});
    chk(x.sel ? "s_tc" : "w_tc", {3'b000, otc}, tc_of(u, x.bin));
    if (x.chk_ham) chk(x.sel ? "s_ham" : "w_ham", 4'($countones(og ^ prev)), x.ham);
    if (x.sel) prev_gs = og; else prev_gw = og;
  endtask

  task automatic step(input bit sel, input logic e, input logic u, input logic l,
                      input logic [3:0] lv);
    exp_t       x;
    logic [3:0] nb, cur;
    logic       wf;
    if (sel) begin
      ifs.en = e; ifs.up = u; ifs.load = l; ifs.load_val = lv;
      ifw.en = 1'b0; ifw.load = 1'b0;
      cur = ms;
      model(ms, 1'b0, e, u, l, lv, nb, wf);
      ms = nb;
    end else begin
      ifw.en = e; ifw.up = u; ifw.load = l; ifw.load_val = lv;
      ifs.en = 1'b0; ifs.load = 1'b0;
      cur = mw;
      model(mw, 1'b1, e, u, l, lv, nb, wf);
      mw = nb;
    end
    x.sel     = sel;
    x.bin     = nb;
    x.g       = GTAB[nb];
    x.wrap    = wf;
    x.chk_ham = !l;
    x.ham     = (nb != cur) ? 4'd1 : 4'd0;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare_one();
  endtask

  task automatic reset_models();
    mw = '0; ms = '0; prev_gw = '0; prev_gs = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifw.en = 1'b0; ifw.up = 1'b1; ifw.load = 1'b0; ifw.load_val = '0;
    ifs.en = 1'b0; ifs.up = 1'b1; ifs.load = 1'b0; ifs.load_val = '0;
    reset_models();

    // Reset state while rst held
    #2;
    chk("rst_g", ifw.g, 4'b0000);
    chk("rst_bin", ifw.bin, 4'b0000);
    chk("rst_wrap", {3'b000, ifw.wrap}, 4'd0);
    chk("rst_tc_up", {3'b000, ifw.tc}, 4'd0);
    ifw.up = 1'b0;
    #1;
    chk("rst_tc_dn", {3'b000, ifw.tc}, 4'd1);
    ifw.up = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Run to g=0110, then async reset between edges
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    #3 rst = 1'b1;
    #1;
    chk("arst_g", ifw.g, 4'b0000);
    chk("arst_bin", ifw.bin, 4'b0000);
    chk("arst_wrap", {3'b000, ifw.wrap}, 4'd0);
    chk("arst_tc", {3'b000, ifw.tc}, 4'd0);
    rst = 1'b0;
    reset_models();

    // Full up sequence with wrap
    repeat (17) step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);

    // Down wrap from reset
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    reset_models();
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

    // Load wins over enable
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0101);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);

    // Saturation at all-ones, then reverse
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    ifs.up = 1'b0;
    #1;
    chk("sat_tc_dn", {3'b000, ifs.tc}, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    // Saturation at zero
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

    // Hold with direction toggling, then reversal
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
    for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b0, logic'(i[0]), 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: observed %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
